// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC/IR owner that fetches one instruction word per sequencer fetch1 entry
// Optional wait timeout with sticky fetch_err is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int              ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [5:0]      FETCH_STATE = 6'd1
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int              TIMEOUT     = 15
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [5:0]        state,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       IR,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_valid,
  output logic              stall,
  output logic              fetch_err
);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fetch_state_t;

  fetch_state_t      fsm, fsm_nxt;
  logic [5:0]        prev_state;
  logic              trig;
  logic [ADDR_W-1:0] pc_nxt, addr_nxt;
  logic [15:0]       ir_nxt;
  logic              req_nxt, irv_nxt, stall_nxt, err_nxt;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
`endif

  // Edge-detect entry into fetch1 so a held state never refetches.
  assign trig = (state == FETCH_STATE) && (prev_state != FETCH_STATE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm        <= F_IDLE;
      prev_state <= 6'd0;
      pc         <= RESET_PC;
      IR         <= 16'h0000;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
      ir_valid   <= 1'b0;
      stall      <= 1'b0;
      fetch_err  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      fsm        <= fsm_nxt;
      prev_state <= state;
      pc         <= pc_nxt;
      IR         <= ir_nxt;
      mem_req    <= req_nxt;
      mem_addr   <= addr_nxt;
      ir_valid   <= irv_nxt;
      stall      <= stall_nxt;
      fetch_err  <= err_nxt;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt   <= wait_cnt_nxt;
`endif
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    pc_nxt    = pc;
    ir_nxt    = IR;
    req_nxt   = mem_req;
    addr_nxt  = mem_addr;
    irv_nxt   = 1'b0;
    stall_nxt = stall;
    err_nxt   = fetch_err;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_nxt = wait_cnt;
`endif
    case (fsm)
      F_IDLE: begin
        if (trig) begin
          fsm_nxt   = F_REQ;
          req_nxt   = 1'b1;
          addr_nxt  = pc;
          stall_nxt = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_nxt = '0;
`endif
        end
      end
      F_REQ, F_WAIT: begin
        if (mem_valid) begin
          fsm_nxt   = F_IDLE;
          ir_nxt    = mem_rdata;
          irv_nxt   = 1'b1;
          req_nxt   = 1'b0;
          stall_nxt = 1'b0;
          pc_nxt    = pc + ADDR_W'(1);
`ifdef FETCH_TIMEOUT_EN
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          // Abandon the fetch with an idle opcode so the sequencer falls back to idle.
          fsm_nxt   = F_IDLE;
          ir_nxt    = 16'h0000;
          irv_nxt   = 1'b1;
          req_nxt   = 1'b0;
          stall_nxt = 1'b0;
          err_nxt   = 1'b1;
        end else begin
          fsm_nxt      = F_WAIT;
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
`else
        end else begin
          fsm_nxt = F_WAIT;
`endif
        end
      end
      default: fsm_nxt = F_IDLE;
    endcase
    // A jump overrides any completion increment; the latched mem_addr is untouched.
    if (pc_load) pc_nxt = pc_load_val;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench for instr_fetch_unit with a transaction-level reference model
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  state;
  logic        pc_load;
  logic [7:0]  pc_load_val;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] IR;
  logic [7:0]  pc;
  logic        ir_valid;
  logic        stall;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  instr_fetch_unit dut (
    .clock(clock), .reset(reset), .state(state), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .mem_req(mem_req), .mem_addr(mem_addr), .IR(IR), .pc(pc),
    .ir_valid(ir_valid), .stall(stall), .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  // Reference model: one outstanding fetch, described as a transaction.
  logic        m_busy;
  logic [7:0]  m_pc, m_addr;
  logic [15:0] m_ir;
  logic        m_irv, m_err;
  logic [5:0]  m_prev;
  int          m_waited;

  always @(posedge clock or posedge reset) begin : model
    logic [7:0]  npc;
    logic [15:0] nir;
    logic        nbusy, nirv, nerr;
    logic [7:0]  naddr;
    int          nwait;
    if (reset) begin
      m_busy <= 1'b0; m_pc <= 8'h00; m_addr <= 8'h00; m_ir <= 16'h0000;
      m_irv <= 1'b0; m_err <= 1'b0; m_prev <= 6'd0; m_waited <= 0;
    end else begin
      npc = m_pc; nir = m_ir; nbusy = m_busy; nirv = 1'b0; nerr = m_err;
      naddr = m_addr; nwait = m_waited;
      if (m_busy) begin
        if (mem_valid) begin
          nir = mem_rdata; nirv = 1'b1; nbusy = 1'b0; npc = m_pc + 8'd1;
        end else begin
          nwait = m_waited + 1;
`ifdef FETCH_TIMEOUT_EN
          if (nwait == 15) begin
            nir = 16'h0000; nirv = 1'b1; nbusy = 1'b0; nerr = 1'b1;
          end
`endif
        end
      end else if (state == 6'd1 && m_prev != 6'd1) begin
        nbusy = 1'b1; naddr = m_pc; nwait = 0;
      end
      if (pc_load) npc = pc_load_val;
      m_pc <= npc; m_ir <= nir; m_busy <= nbusy; m_irv <= nirv; m_err <= nerr;
      m_addr <= naddr; m_waited <= nwait; m_prev <= state;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("pc", {8'h00, pc}, {8'h00, m_pc});
    chk("IR", IR, m_ir);
    chk("mem_req", {15'd0, mem_req}, {15'd0, m_busy});
    chk("stall", {15'd0, stall}, {15'd0, m_busy});
    chk("mem_addr", {8'h00, mem_addr}, {8'h00, m_addr});
    chk("ir_valid", {15'd0, ir_valid}, {15'd0, m_irv});
    chk("fetch_err", {15'd0, fetch_err}, {15'd0, m_err});
    if (ir_valid === 1'b1) pulses++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Enter fetch1 for one cycle, answer after 'delay' wait cycles.
  task automatic fetch(input logic [15:0] data, input int delay);
    state = 6'd1;
    cyc(1);
    state = 6'd0;
    cyc(delay);
    mem_valid = 1'b1; mem_rdata = data;
    cyc(1);
    mem_valid = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  int p0;

  initial begin
    reset = 1'b1; state = 6'd0; pc_load = 1'b0; pc_load_val = 8'h00;
    mem_rdata = 16'h0000; mem_valid = 1'b0;
    cyc(2);
    chk("reset_pc", {8'h00, pc}, 16'h0000);
    chk("reset_req", {15'd0, mem_req}, 16'h0000);
    reset = 1'b0;
    cyc(1);

    // T1
    p0 = pulses;
    state = 6'd1;
    cyc(1);
    chk("t1_req_up", {15'd0, mem_req}, 16'h0001);
    chk("t1_stall_up", {15'd0, stall}, 16'h0001);
    state = 6'd0;
    cyc(1);
    mem_valid = 1'b1; mem_rdata = 16'h1C05;
    cyc(1);
    mem_valid = 1'b0;
    chk("t1_irv", {15'd0, ir_valid}, 16'h0001);
    cyc(1);
    chk("t1_ir", IR, 16'h1C05);
    chk("t1_pc", {8'h00, pc}, 16'h0001);
    chk("t1_addr", {8'h00, mem_addr}, 16'h0000);
    chk("t1_pulses", 16'(pulses - p0), 16'd1);

    // T2
    do_reset();
    p0 = pulses;
    state = 6'd1;
    cyc(1);
    mem_valid = 1'b1; mem_rdata = 16'h2468;
    cyc(1);
    mem_valid = 1'b0;
    cyc(3);
    state = 6'd0;
    cyc(2);
    chk("t2_pulses", 16'(pulses - p0), 16'd1);
    chk("t2_pc", {8'h00, pc}, 16'h0001);
    chk("t2_ir", IR, 16'h2468);

    // T3
    pc_load = 1'b1; pc_load_val = 8'hFF;
    cyc(1);
    pc_load = 1'b0;
    fetch(16'hA55A, 0);
    chk("t3_addr", {8'h00, mem_addr}, 16'h00FF);
    chk("t3_wrap", {8'h00, pc}, 16'h0000);
    state = 6'd1;
    cyc(1);
    state = 6'd0;
    cyc(1);
    mem_valid = 1'b1; mem_rdata = 16'h3333; pc_load = 1'b1; pc_load_val = 8'h40;
    cyc(1);
    mem_valid = 1'b0; pc_load = 1'b0;
    chk("t3_load_wins", {8'h00, pc}, 16'h0040);
    chk("t3_ir", IR, 16'h3333);
    cyc(1);
    state = 6'd1; pc_load = 1'b1; pc_load_val = 8'h80;
    cyc(1);
    state = 6'd0; pc_load = 1'b0;
    chk("t3_old_pc_addr", {8'h00, mem_addr}, 16'h0040);
    chk("t3_loaded", {8'h00, pc}, 16'h0080);
    cyc(1);
    mem_valid = 1'b1; mem_rdata = 16'h0F0F;
    cyc(1);
    mem_valid = 1'b0;
    chk("t3_inc_after_load", {8'h00, pc}, 16'h0081);
    cyc(1);

    // T4
    p0 = pulses;
    state = 6'd1;
    cyc(1);
    state = 6'd0;
    cyc(1);
    reset = 1'b1;
    #1;
    chk("t4_async_req", {15'd0, mem_req}, 16'h0000);
    mem_valid = 1'b1; mem_rdata = 16'hBEEF;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    mem_valid = 1'b0;
    cyc(1);
    chk("t4_ir", IR, 16'h0000);
    chk("t4_pc", {8'h00, pc}, 16'h0000);
    chk("t4_pulses", 16'(pulses - p0), 16'd0);

    // T6
    fetch(16'h1234, 1);
    p0 = pulses;
    mem_valid = 1'b1; mem_rdata = 16'hFFFF;
    cyc(3);
    mem_valid = 1'b0;
    cyc(1);
    chk("t6_ir", IR, 16'h1234);
    chk("t6_pc", {8'h00, pc}, 16'h0001);
    chk("t6_pulses", 16'(pulses - p0), 16'd0);

    // T5: long wait with no response
    state = 6'd1;
    cyc(1);
    state = 6'd0;
    cyc(20);
`ifdef FETCH_TIMEOUT_EN
    chk("t5_err", {15'd0, fetch_err}, 16'h0001);
    chk("t5_ir", IR, 16'h0000);
    chk("t5_req", {15'd0, mem_req}, 16'h0000);
    chk("t5_pc", {8'h00, pc}, 16'h0001);
    fetch(16'h5A5A, 2);
    chk("t5_err_sticky", {15'd0, fetch_err}, 16'h0001);
    chk("t5_ir_next", IR, 16'h5A5A);
    chk("t5_pc_next", {8'h00, pc}, 16'h0002);
`else
    chk("t5_still_req", {15'd0, mem_req}, 16'h0001);
    chk("t5_no_err", {15'd0, fetch_err}, 16'h0000);
    mem_valid = 1'b1; mem_rdata = 16'h5A5A;
    cyc(1);
    mem_valid = 1'b0;
    cyc(1);
    chk("t5_ir_late", IR, 16'h5A5A);
    chk("t5_pc_late", {8'h00, pc}, 16'h0002);
`endif
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
